// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder model.
package sram_pkg;

    localparam int SRAM_DQ_W    = 16;
    localparam int SRAM_ADDR_W  = 18;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_READ_WAIT  = 2'd1;
    localparam state_t ST_READ_DRIVE = 2'd2;

endpackage

// File: rtl/sram_array.sv
// Single-port 16-bit storage with per-byte write enables and asynchronous read.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic                 clk,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [SRAM_DQ_W-1:0] wdata,
    input  logic                 we_hi,
    input  logic                 we_lo,
    output logic [SRAM_DQ_W-1:0] rdata
);

    logic [SRAM_DQ_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we_hi) mem[addr][15:8] <= wdata[15:8];
        if (we_lo) mem[addr][7:0]  <= wdata[7:0];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// Behavioural asynchronous-SRAM target with programmable read latency.
// Optional protocol checker enabled by defining SRAM_RESP_CONFLICT_CHECK_EN.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int READ_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    input  logic                   SRAM_UB_N,
    input  logic                   SRAM_LB_N,
    input  logic                   SRAM_WE_N,
    input  logic                   SRAM_CE_N,
    input  logic                   SRAM_OE_N,
    output logic                   rd_valid,
    output logic                   bus_err
);

    localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);
    localparam state_t     START_ST = (READ_LAT == 1) ? ST_READ_DRIVE : ST_READ_WAIT;

    state_t               state;
    logic [2:0]           lat_cnt;
    logic [ADDR_W-1:0]    addr;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    port_addr;
    logic [SRAM_DQ_W-1:0] rdata;
    logic                 write_cyc;
    logic                 read_req;
    logic                 drive_en;

    assign addr      = SRAM_ADDR[ADDR_W-1:0];
    assign write_cyc = !SRAM_CE_N && !SRAM_WE_N;
    assign read_req  = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;

    // One physical port: writes use the live address, reads the latched one.
    assign port_addr = write_cyc ? addr : addr_q;

    sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .addr  (port_addr),
        .wdata (SRAM_DQ),
        .we_hi (write_cyc && !SRAM_UB_N && rst),
        .we_lo (write_cyc && !SRAM_LB_N && rst),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            addr_q  <= '0;
        end else if (write_cyc) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read_req) begin
                        addr_q  <= addr;
                        lat_cnt <= LAT_INIT;
                        state   <= START_ST;
                    end
                end
                ST_READ_WAIT: begin
                    if (!read_req) begin
                        state <= ST_IDLE;
                    end else if (addr != addr_q) begin
                        addr_q  <= addr;
                        lat_cnt <= LAT_INIT;
                        state   <= START_ST;
                    end else if (lat_cnt <= 3'd1) begin
                        // Counter reaches zero on this edge, so drive starts now.
                        lat_cnt <= '0;
                        state   <= ST_READ_DRIVE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_READ_DRIVE: begin
                    if (!read_req) begin
                        state <= ST_IDLE;
                    end else if (addr != addr_q) begin
                        addr_q  <= addr;
                        lat_cnt <= LAT_INIT;
                        state   <= START_ST;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus release follows the control pins combinationally, not the next edge.
    assign drive_en = (state == ST_READ_DRIVE) && read_req;
    assign rd_valid = drive_en;

    assign SRAM_DQ[15:8] = (drive_en && !SRAM_UB_N) ? rdata[15:8] : 8'bz;
    assign SRAM_DQ[7:0]  = (drive_en && !SRAM_LB_N) ? rdata[7:0]  : 8'bz;

`ifdef SRAM_RESP_CONFLICT_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (write_cyc && (!SRAM_OE_N || (SRAM_UB_N && SRAM_LB_N))) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (READ_LAT=2); released bus reads as all ones.
module tb_sram_responder;
    import sram_pkg::*;

`ifdef SRAM_RESP_CONFLICT_CHECK_EN
    localparam logic [15:0] EXP_ERR = 16'd1;
`else
    localparam logic [15:0] EXP_ERR = 16'd0;
`endif
    localparam logic [15:0] REL = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic        rd_valid, bus_err;
    logic [15:0] tb_dq;
    logic        tb_en;
    tri1  [15:0] dq;

    int n_cmp = 0;
    int n_bad = 0;

    assign dq = tb_en ? tb_dq : 16'bz;

    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(18), .READ_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (dq),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .rd_valid  (rd_valid),
        .bus_err   (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ce_n  = 1'b1;
        we_n  = 1'b1;
        oe_n  = 1'b1;
        ub_n  = 1'b0;
        lb_n  = 1'b0;
        tb_en = 1'b0;
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic u, input logic l);
        sram_addr = a;
        tb_dq     = d;
        tb_en     = 1'b1;
        ub_n      = u;
        lb_n      = l;
        ce_n      = 1'b0;
        we_n      = 1'b0;
        tick();
        idle();
    endtask

    task automatic rd_to_drive(input logic [17:0] a);
        sram_addr = a;
        ce_n      = 1'b0;
        oe_n      = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        sram_addr = '0;
        tb_dq     = '0;
        idle();
        #2;
        check("reset_vld", {15'd0, rd_valid}, 16'd0);
        check("reset_err", {15'd0, bus_err}, 16'd0);
        check("reset_dq", dq, REL);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic write then read with two-clock latency
        wr(18'h00010, 16'hA5C3, 1'b0, 1'b0);
        sram_addr = 18'h00010;
        ce_n = 1'b0;
        oe_n = 1'b0;
        #1;
        check("rd_z1", dq, REL);
        check("rd_z1_vld", {15'd0, rd_valid}, 16'd0);
        tick();
        check("rd_z2", dq, REL);
        tick();
        check("rd_data", dq, 16'hA5C3);
        check("rd_vld", {15'd0, rd_valid}, 16'd1);
        ub_n = 1'b1;
        #1;
        check("rd_lane_lo", dq, 16'hFFC3);
        ub_n = 1'b0;
        tick();
        check("rd_hold", dq, 16'hA5C3);

        // OE_N raised while driving
        oe_n = 1'b1;
        #1;
        check("oe_rel_dq", dq, REL);
        check("oe_rel_vld", {15'd0, rd_valid}, 16'd0);
        tick();
        oe_n = 1'b0;
        #1;
        check("oe_idle", dq, REL);
        idle();
        tick();

        // Byte-masked write merge
        wr(18'h00003, 16'h1122, 1'b0, 1'b0);
        wr(18'h00003, 16'hFF00, 1'b0, 1'b1);
        wr(18'h00005, 16'h1234, 1'b0, 1'b0);
        wr(18'h00006, 16'hBEEF, 1'b0, 1'b0);
        rd_to_drive(18'h00003);
        check("mask_merge", dq, 16'hFF22);
        idle();
        tick();

        // Address change during wait restarts latency
        sram_addr = 18'h00005;
        ce_n = 1'b0;
        oe_n = 1'b0;
        tick();
        sram_addr = 18'h00006;
        #1;
        check("chg_wait", dq, REL);
        tick();
        check("chg_z", dq, REL);
        check("chg_z_vld", {15'd0, rd_valid}, 16'd0);
        tick();
        check("chg_data", dq, 16'hBEEF);
        idle();
        tick();

        // Request dropped during wait returns to idle
        sram_addr = 18'h00005;
        ce_n = 1'b0;
        oe_n = 1'b0;
        tick();
        ce_n = 1'b1;
        tick();
        ce_n = 1'b0;
        #1;
        check("abort_idle", dq, REL);
        tick();
        check("abort_wait", dq, REL);
        tick();
        check("abort_data", dq, 16'h1234);

        // Write while driving takes priority
        tb_dq = 16'h5A5A;
        tb_en = 1'b1;
        we_n  = 1'b0;
        #1;
        check("wr_prio_vld", {15'd0, rd_valid}, 16'd0);
        tick();
        we_n  = 1'b1;
        tb_en = 1'b0;
        #1;
        check("wr_prio_idle", dq, REL);
        check("err_wr_oe", {15'd0, bus_err}, EXP_ERR);
        tick();
        tick();
        check("raw_data", dq, 16'h5A5A);

        // Asynchronous reset while driving
        rst = 1'b0;
        #1;
        check("rst_dq", dq, REL);
        check("rst_vld", {15'd0, rd_valid}, 16'd0);
        check("rst_err", {15'd0, bus_err}, 16'd0);
        idle();
        tick();
        rst = 1'b1;
        tick();
        rd_to_drive(18'h00010);
        check("post_rst_10", dq, 16'hA5C3);
        idle();
        tick();
        rd_to_drive(18'h00003);
        check("post_rst_3", dq, 16'hFF22);
        idle();
        tick();

        // Conflict detection
        check("err_pre", {15'd0, bus_err}, 16'd0);
        sram_addr = 18'h0007F;
        tb_dq = 16'h0000;
        tb_en = 1'b1;
        ce_n  = 1'b0;
        we_n  = 1'b0;
        oe_n  = 1'b0;
        tick();
        idle();
        check("err_set", {15'd0, bus_err}, EXP_ERR);
        tick();
        tick();
        check("err_sticky", {15'd0, bus_err}, EXP_ERR);
        rst = 1'b0;
        #1;
        check("err_clr", {15'd0, bus_err}, 16'd0);
        tick();
        rst = 1'b1;
        tick();

        // Write with both lanes masked stores nothing
        wr(18'h00010, 16'h0000, 1'b1, 1'b1);
        check("err_nomask", {15'd0, bus_err}, EXP_ERR);
        rd_to_drive(18'h00010);
        check("nomask_data", dq, 16'hA5C3);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 18, number of array address bits used (array depth 2^ADDR_W 16-bit words).
REQ-002 Parameter READ_LAT, default 2, legal 1..7, clocks from read request sampled to SRAM_DQ driven.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 SRAM_ADDR  input  18  word address; bits [ADDR_W-1:0] used, upper bits ignored.
REQ-006 SRAM_DQ  inout  16  data bus; driven only during read drive, else high-Z.
REQ-007 SRAM_UB_N  input  1  high-byte lane enable, active-low.
REQ-008 SRAM_LB_N  input  1  low-byte lane enable, active-low.
REQ-009 SRAM_WE_N  input  1  write enable, active-low.
REQ-010 SRAM_CE_N  input  1  chip enable, active-low.
REQ-011 SRAM_OE_N  input  1  output enable, active-low.
REQ-012 rd_valid  output  1  high while SRAM_DQ carries read data.
REQ-013 bus_err  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-014 FSM states: IDLE, READ_WAIT, READ_DRIVE; 3-bit latency counter lat_cnt.
REQ-015 Write cycle = CE_N=0 and WE_N=0, sampled at rising edge, any state; OE_N ignored.
REQ-016 Each write edge stores SRAM_DQ[15:8] to addr if UB_N=0, SRAM_DQ[7:0] if LB_N=0; both masks high = no store.
REQ-017 Write in any state forces state IDLE next cycle and releases SRAM_DQ; write has priority over read.
REQ-018 Read request = CE_N=0, WE_N=1, OE_N=0 sampled in IDLE: latch address, lat_cnt=READ_LAT-1, go READ_WAIT (READ_LAT=1: go directly READ_DRIVE).
REQ-019 READ_WAIT: lat_cnt decrements each clock; at 0 go READ_DRIVE.
REQ-020 READ_DRIVE: SRAM_DQ[15:8] = array[latched addr][15:8] if UB_N=0 else Z; [7:0] likewise with LB_N; rd_valid=1.
REQ-021 Drive qualified combinationally: CE_N=1 or OE_N=1 or WE_N=0 releases SRAM_DQ same cycle; state returns IDLE next edge.
REQ-022 Address change in READ_WAIT or READ_DRIVE (request still asserted): relatch address, restart READ_WAIT with full latency.
REQ-023 Request deasserted in READ_WAIT: return IDLE, no drive.
REQ-024 Read after write to same address returns newly written bytes; unwritten lanes keep old value.
REQ-025 Read latency READ_LAT clocks from the sampling edge to first drive edge; data held stable while request and address unchanged.

Reset
REQ-026 rst=0: state IDLE, lat_cnt 0, latched address 0, rd_valid 0, bus_err 0, SRAM_DQ Z, all immediately (asynchronous).
REQ-027 Array contents not reset; reset mid-read aborts read and releases bus before next edge.
REQ-028 Reset mid-write: the in-progress edge's store is not guaranteed; no other locations altered.

Configuration
REQ-029 Macro SRAM_RESP_CONFLICT_CHECK_EN defined: bus_err sets (sticky until reset) on any edge sampling CE_N=0, WE_N=0, OE_N=0, or a write with both byte masks high.
REQ-030 Macro undefined: bus_err tied 0, no check logic; all other behaviour identical.

Structure
REQ-031 Shared package sram_pkg holds FSM state typedef, SRAM_DQ_W=16, SRAM_ADDR_W=18, READ_LAT bounds.
REQ-032 Sub-module sram_array: single-port 16-bit array, 2 byte-write enables, async read by address, no reset.

Verification
REQ-033 Write 0xA5C3 to 0x00010 (UB/LB=0), read 0x00010 with READ_LAT=2 -> DQ Z for 2 clocks, then 0xA5C3, rd_valid=1.
REQ-034 Write 0x1122 to 0x3, then write 0xFF00 with UB_N=0, LB_N=1 -> read 0x3 returns 0xFF22.
REQ-035 Read in progress, OE_N raised in READ_DRIVE -> DQ Z same cycle, rd_valid 0, state IDLE next edge.
REQ-036 Address 0x5 -> 0x6 during READ_WAIT -> drive delayed full READ_LAT from change, data = array[0x6].
REQ-037 Macro defined: CE_N=0, WE_N=0, OE_N=0 one clock -> bus_err=1 held until rst=0; macro undefined -> bus_err stays 0.
REQ-038 rst asserted during READ_DRIVE -> DQ Z and rd_valid 0 without clock edge; previously written data intact after reset.
